// File: rtl/trigger_sequencer.sv
// Multi-stage trigger engine: walks up to `levels` match stages over the sample
// stream and produces ring-buffer store qualifiers plus a post-trigger countdown.
module trigger_sequencer #(
  parameter int size    = 32,
  parameter int levels  = 8,
  parameter int saddr_w = 24,
  parameter int cnt_w   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_en,
  input  logic [size-1:0]            dinput,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [$clog2(levels):0]    num_levels,
  input  logic [levels*size-1:0]     trig_mask,
  input  logic [levels*size-1:0]     trig_type,
  input  logic [levels*size-1:0]     trig_level,
  input  logic [levels-1:0]          trig_mode,
  input  logic [levels*cnt_w-1:0]    trig_count,
  input  logic [saddr_w-1:0]         post_trigger_count,
  input  logic [saddr_w-1:0]         buffer_size,
  output logic                       ready,
  output logic                       armed,
  output logic                       triggered,
  output logic                       done,
  output logic [$clog2(levels)-1:0]  stage,
  output logic                       store,
  output logic [saddr_w-1:0]         sample_addr,
  output logic [saddr_w-1:0]         trigger_pos,
  output logic [1:0]                 state_dbg
);

  localparam int SW = $clog2(levels);
  localparam int NW = $clog2(levels) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  state_t             state_q;
  logic               ready_q, armed_q, triggered_q, done_q, store_q;
  logic [SW-1:0]      stage_q;
  logic [cnt_w-1:0]   occ_q;
  logic [saddr_w-1:0] wptr_q, postcnt_q, sample_addr_q, trigger_pos_q;
  logic [size-1:0]    prev_q;
  logic               prev_valid_q;

  logic [size-1:0]    mask_s, type_s, lvl_s, bit_lvl, bit_edge, bit_match;
  logic               mode_s, stage_match, stage_done;
  logic [cnt_w-1:0]   cnt_s, need_s;
  logic [cnt_w:0]     occ_inc;
  logic [NW-1:0]      nl_eff;
  logic [SW-1:0]      last_idx;
  logic [saddr_w-1:0] wptr_inc;

  always_comb begin
    mask_s = '0;
    type_s = '0;
    lvl_s  = '0;
    mode_s = 1'b0;
    cnt_s  = '0;
    for (int k = 0; k < levels; k++) begin
      if (stage_q == SW'(k)) begin
        mask_s = trig_mask[k*size +: size];
        type_s = trig_type[k*size +: size];
        lvl_s  = trig_level[k*size +: size];
        mode_s = trig_mode[k];
        cnt_s  = trig_count[k*cnt_w +: cnt_w];
      end
    end
    // Edge bits never match on the first sample after arm: no previous value yet.
    bit_lvl   = ~(dinput ^ lvl_s);
    bit_edge  = {size{prev_valid_q}} & (prev_q ^ dinput) & bit_lvl;
    bit_match = (type_s & bit_edge) | (~type_s & bit_lvl);
    if (mask_s == '0)
      stage_match = 1'b1;
    else if (mode_s)
      stage_match = |(bit_match & mask_s);
    else
      stage_match = &(bit_match | ~mask_s);
    need_s     = (cnt_s == '0) ? cnt_w'(1) : cnt_s;
    occ_inc    = {1'b0, occ_q} + (cnt_w+1)'(1);
    stage_done = stage_match && (occ_inc >= {1'b0, need_s});

    if (num_levels == '0)
      nl_eff = NW'(1);
    else if (num_levels > NW'(levels))
      nl_eff = NW'(levels);
    else
      nl_eff = num_levels;
    last_idx = SW'(nl_eff - NW'(1));

    wptr_inc = (wptr_q == buffer_size - saddr_w'(1)) ? '0 : wptr_q + saddr_w'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      armed_q       <= 1'b0;
      triggered_q   <= 1'b0;
      done_q        <= 1'b0;
      store_q       <= 1'b0;
      stage_q       <= '0;
      occ_q         <= '0;
      wptr_q        <= '0;
      postcnt_q     <= '0;
      sample_addr_q <= '0;
      trigger_pos_q <= '0;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
    end else begin
      store_q <= 1'b0;
      if (abort) begin
        state_q       <= S_IDLE;
        ready_q       <= 1'b1;
        armed_q       <= 1'b0;
        triggered_q   <= 1'b0;
        done_q        <= 1'b0;
        stage_q       <= '0;
        occ_q         <= '0;
        trigger_pos_q <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              state_q       <= S_ARMED;
              ready_q       <= 1'b0;
              armed_q       <= 1'b1;
              triggered_q   <= 1'b0;
              done_q        <= 1'b0;
              stage_q       <= '0;
              occ_q         <= '0;
              wptr_q        <= '0;
              trigger_pos_q <= '0;
              prev_valid_q  <= 1'b0;
            end
          end
          S_ARMED: begin
            if (sample_en) begin
              store_q       <= 1'b1;
              sample_addr_q <= wptr_q;
              wptr_q        <= wptr_inc;
              prev_q        <= dinput;
              prev_valid_q  <= 1'b1;
              if (stage_done) begin
                occ_q <= '0;
                if (stage_q >= last_idx) begin
                  triggered_q   <= 1'b1;
                  trigger_pos_q <= wptr_q;
                  postcnt_q     <= post_trigger_count;
                  armed_q       <= 1'b0;
                  if (post_trigger_count == '0) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                  end else begin
                    state_q <= S_POST;
                  end
                end else begin
                  // Next stage starts on the following sample, never this one.
                  stage_q <= stage_q + SW'(1);
                end
              end else if (stage_match) begin
                occ_q <= occ_inc[cnt_w-1:0];
              end
            end
          end
          S_POST: begin
            if (sample_en) begin
              store_q       <= 1'b1;
              sample_addr_q <= wptr_q;
              wptr_q        <= wptr_inc;
              postcnt_q     <= postcnt_q - saddr_w'(1);
              if (postcnt_q == saddr_w'(1)) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                ready_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ready       = ready_q;
  assign armed       = armed_q;
  assign triggered   = triggered_q;
  assign done        = done_q;
  assign stage       = stage_q;
  assign store       = store_q;
  assign sample_addr = sample_addr_q;
  assign trigger_pos = trigger_pos_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: each task drives one scenario and
// compares registered outputs against hand-computed values.
module tb_trigger_sequencer;

  localparam int SIZE = 32;
  localparam int LEV  = 8;
  localparam int AW   = 24;
  localparam int CW   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              sample_en = 1'b0;
  logic [SIZE-1:0]   dinput = '0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [3:0]        num_levels = 4'd1;
  logic [LEV*SIZE-1:0] trig_mask = '0;
  logic [LEV*SIZE-1:0] trig_type = '0;
  logic [LEV*SIZE-1:0] trig_level = '0;
  logic [LEV-1:0]    trig_mode = '0;
  logic [LEV*CW-1:0] trig_count = '0;
  logic [AW-1:0]     post_trigger_count = '0;
  logic [AW-1:0]     buffer_size = 24'd128;
  logic              ready, armed, triggered, done, store;
  logic [2:0]        stage;
  logic [AW-1:0]     sample_addr, trigger_pos;
  logic [1:0]        state_dbg;

  int vectors = 0;
  int errors  = 0;

  trigger_sequencer #(.size(SIZE), .levels(LEV), .saddr_w(AW), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .dinput(dinput),
    .arm(arm), .abort(abort), .num_levels(num_levels),
    .trig_mask(trig_mask), .trig_type(trig_type), .trig_level(trig_level),
    .trig_mode(trig_mode), .trig_count(trig_count),
    .post_trigger_count(post_trigger_count), .buffer_size(buffer_size),
    .ready(ready), .armed(armed), .triggered(triggered), .done(done),
    .stage(stage), .store(store), .sample_addr(sample_addr),
    .trigger_pos(trigger_pos), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Driver tasks: called just after a rising edge, they return 1 ns after the next one.
  task automatic send(input logic [SIZE-1:0] d);
    dinput = d;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic pulse_arm(input logic with_abort);
    arm = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    arm = 1'b0;
    abort = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic cfg_clear(input logic [3:0] nl, input logic [AW-1:0] post,
                           input logic [AW-1:0] bsz);
    trig_mask = '0; trig_type = '0; trig_level = '0; trig_mode = '0; trig_count = '0;
    num_levels = nl;
    post_trigger_count = post;
    buffer_size = bsz;
  endtask

  task automatic cfg_stage(input int k, input logic [SIZE-1:0] m, input logic [SIZE-1:0] t,
                           input logic [SIZE-1:0] l, input logic md, input logic [CW-1:0] c);
    trig_mask[k*SIZE +: SIZE]  = m;
    trig_type[k*SIZE +: SIZE]  = t;
    trig_level[k*SIZE +: SIZE] = l;
    trig_mode[k]               = md;
    trig_count[k*CW +: CW]     = c;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    vectors++; if ({armed, triggered, done, store} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {armed, triggered, done, store}); end
    vectors++; if (stage !== 3'd0 || sample_addr !== '0 || trigger_pos !== '0) begin errors++; $display("FAIL reset_regs got stage=%0d addr=%0d tpos=%0d want 0", stage, sample_addr, trigger_pos); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_level();
    logic [SIZE-1:0] seq [7] = '{0, 0, 1, 0, 0, 0, 0};
    cfg_clear(4'd1, 24'd4, 24'd128);
    cfg_stage(0, 32'h1, 32'h0, 32'h1, 1'b0, 16'd1);
    pulse_arm(1'b0);
    vectors++; if (armed !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL single_armed got armed=%b ready=%b want 1 0", armed, ready); end
    for (int i = 0; i < 7; i++) begin
      send(seq[i]);
      vectors++; if (store !== 1'b1 || sample_addr !== AW'(i)) begin errors++; $display("FAIL single_store[%0d] got store=%b addr=%0d want 1 %0d", i, store, sample_addr, i); end
      vectors++; if (triggered !== (i >= 2)) begin errors++; $display("FAIL single_trig[%0d] got %b want %b", i, triggered, (i >= 2)); end
      vectors++; if (done !== (i == 6)) begin errors++; $display("FAIL single_done[%0d] got %b want %b", i, done, (i == 6)); end
    end
    vectors++; if (trigger_pos !== 24'd2) begin errors++; $display("FAIL single_tpos got %0d want 2", trigger_pos); end
    vectors++; if (ready !== 1'b1 || armed !== 1'b0) begin errors++; $display("FAIL single_ready got ready=%b armed=%b want 1 0", ready, armed); end
    send(32'h0);
    vectors++; if (store !== 1'b0) begin errors++; $display("FAIL single_nostore_done got %b want 0", store); end
  endtask

  task automatic test_two_stage_edge();
    cfg_clear(4'd2, 24'd0, 24'd128);
    cfg_stage(0, 32'h1, 32'h1, 32'h1, 1'b0, 16'd1);
    cfg_stage(1, 32'h2, 32'h2, 32'h0, 1'b0, 16'd1);
    pulse_arm(1'b0);
    send(32'h0);
    vectors++; if (stage !== 3'd0) begin errors++; $display("FAIL edge_stage0 got %0d want 0", stage); end
    send(32'h1);
    vectors++; if (stage !== 3'd1) begin errors++; $display("FAIL edge_stage1 got %0d want 1", stage); end
    send(32'h3);
    vectors++; if (triggered !== 1'b0) begin errors++; $display("FAIL edge_rise_not_fall got %b want 0", triggered); end
    send(32'h1);
    vectors++; if (triggered !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL edge_trig_done got trig=%b done=%b want 1 1", triggered, done); end
    vectors++; if (trigger_pos !== 24'd3) begin errors++; $display("FAIL edge_tpos got %0d want 3", trigger_pos); end
  endtask

  task automatic test_occurrence();
    logic [SIZE-1:0] seq [5] = '{1, 0, 1, 0, 1};
    cfg_clear(4'd1, 24'd0, 24'd128);
    cfg_stage(0, 32'h1, 32'h0, 32'h1, 1'b0, 16'd3);
    pulse_arm(1'b0);
    for (int i = 0; i < 5; i++) begin
      send(seq[i]);
      vectors++; if (triggered !== (i == 4)) begin errors++; $display("FAIL occ_trig[%0d] got %b want %b", i, triggered, (i == 4)); end
    end
    vectors++; if (trigger_pos !== 24'd4) begin errors++; $display("FAIL occ_tpos got %0d want 4", trigger_pos); end
  endtask

  task automatic test_or_zero_mask();
    cfg_clear(4'd2, 24'd0, 24'd128);
    cfg_stage(0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    cfg_stage(1, 32'hF0, 32'h0, 32'h00, 1'b1, 16'd1);
    pulse_arm(1'b0);
    send(32'hFF);
    vectors++; if (stage !== 3'd1 || triggered !== 1'b0) begin errors++; $display("FAIL or_zmask got stage=%0d trig=%b want 1 0", stage, triggered); end
    send(32'hFF);
    vectors++; if (triggered !== 1'b0) begin errors++; $display("FAIL or_nomatch got %b want 0", triggered); end
    send(32'hEF);
    vectors++; if (triggered !== 1'b1 || trigger_pos !== 24'd2) begin errors++; $display("FAIL or_trig got trig=%b tpos=%0d want 1 2", triggered, trigger_pos); end
  endtask

  task automatic test_wrap();
    cfg_clear(4'd1, 24'd0, 24'd4);
    cfg_stage(0, 32'h1, 32'h0, 32'h1, 1'b0, 16'd1);
    pulse_arm(1'b0);
    for (int i = 0; i < 10; i++) begin
      // A re-arm while capturing must not restart the write pointer.
      if (i == 5) pulse_arm(1'b0);
      send(32'h0);
      vectors++; if (store !== 1'b1 || sample_addr !== AW'(i % 4)) begin errors++; $display("FAIL wrap_addr[%0d] got store=%b addr=%0d want 1 %0d", i, store, sample_addr, i % 4); end
    end
    vectors++; if (triggered !== 1'b0 || armed !== 1'b1) begin errors++; $display("FAIL wrap_state got trig=%b armed=%b want 0 1", triggered, armed); end
    pulse_abort();
  endtask

  task automatic test_abort_and_reset();
    cfg_clear(4'd0, 24'd0, 24'd128);
    cfg_stage(0, 32'h1, 32'h0, 32'h1, 1'b0, 16'd1);
    pulse_arm(1'b0);
    send(32'h1);
    vectors++; if (done !== 1'b1 || triggered !== 1'b1) begin errors++; $display("FAIL nl0_done got done=%b trig=%b want 1 1", done, triggered); end
    pulse_arm(1'b1);
    vectors++; if (ready !== 1'b1 || armed !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_arm got ready=%b armed=%b done=%b want 1 0 0", ready, armed, done); end

    post_trigger_count = 24'd4;
    pulse_arm(1'b0);
    send(32'h1);
    vectors++; if (triggered !== 1'b1 || armed !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL post_entry got trig=%b armed=%b ready=%b want 1 0 0", triggered, armed, ready); end
    pulse_abort();
    vectors++; if (triggered !== 1'b0 || ready !== 1'b1 || store !== 1'b0) begin errors++; $display("FAIL post_abort got trig=%b ready=%b store=%b want 0 1 0", triggered, ready, store); end

    cfg_stage(0, 32'h1, 32'h0, 32'h1, 1'b0, 16'd5);
    pulse_arm(1'b0);
    send(32'h0);
    send(32'h0);
    vectors++; if (armed !== 1'b1 || sample_addr !== 24'd1) begin errors++; $display("FAIL pre_reset got armed=%b addr=%0d want 1 1", armed, sample_addr); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (ready !== 1'b1 || armed !== 1'b0 || store !== 1'b0) begin errors++; $display("FAIL async_reset_flags got ready=%b armed=%b store=%b want 1 0 0", ready, armed, store); end
    vectors++; if (sample_addr !== '0 || trigger_pos !== '0 || stage !== 3'd0) begin errors++; $display("FAIL async_reset_regs got addr=%0d tpos=%0d stage=%0d want 0", sample_addr, trigger_pos, stage); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_level();
    test_two_stage_edge();
    test_occurrence();
    test_or_zero_mask();
    test_wrap();
    test_abort_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
